// File: rtl/mips_alu_pkg.sv
// Shared encodings for the MIPS execute unit: ALUControl codes and MDU FSM states.
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_MFLO  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } mdu_state_e;

endpackage

// File: rtl/mips_alu_mdu_if.sv
// Execute-stage bus between control/datapath (master) and the ALU/MDU (slave).
interface mips_alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ALUControl;
    logic             Start;
    logic [WIDTH-1:0] ALUResult;
    logic             ZeroFlag;
    logic             Overflow;
    logic             Busy;
    logic             Done;
    logic             DivZero;

    modport master (
        output SrcA, SrcB, ALUControl, Start,
        input  ALUResult, ZeroFlag, Overflow, Busy, Done, DivZero
    );

    modport slave (
        input  SrcA, SrcB, ALUControl, Start,
        output ALUResult, ZeroFlag, Overflow, Busy, Done, DivZero
    );
endinterface

// File: rtl/mips_mdu_seq.sv
// Iterative MULTU/DIVU engine: one shift-add or restoring-divide step per clock,
// with HI/LO written only when an operation completes.
module mips_mdu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic [3:0]       op_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o
);
    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;   // {partial product | remainder, multiplier | quotient}
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               launch;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;

    assign launch = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i &&
                    ((op_i == ALU_MULTU) || (op_i == ALU_DIVU));

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        // Borrow out of the trial subtract (bit WIDTH) means restore the old remainder.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opb_q};
        div_step  = div_diff[WIDTH] ? {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    end

    // NOTE: every variable gets a default first, so no path through the case leaves a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        case (state_q)
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_step : div_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    hi_d    = acc_d[2*WIDTH-1:WIDTH];
                    lo_d    = acc_d[WIDTH-1:0];
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                if (launch) begin
                    acc_d      = {{WIDTH{1'b0}}, src_a_i};
                    opb_d      = src_b_i;
                    cnt_d      = CNT_W'(WIDTH - 1);
                    div_zero_d = 1'b0;
                    if (op_i == ALU_MULTU) begin
                        state_d = S_MUL;
                    end else if (src_b_i != '0) begin
                        state_d = S_DIV;
                    end else begin
                        hi_d       = src_a_i;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign busy_o     = (state_q == S_MUL) || (state_q == S_DIV);
    assign done_o     = (state_q == S_DONE);
    assign div_zero_o = div_zero_q;

endmodule

// File: rtl/mips_alu_mdu.sv
// MIPS execute unit top: combinational ALU and result mux around the iterative MDU.
module mips_alu_mdu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RST,
    mips_alu_mdu_if.slave  bus
);
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] result;
    logic             ovf;

    mips_mdu_seq #(.WIDTH(WIDTH)) u_mdu (
        .clk_i      (CLK),
        .rst_i      (RST),
        .src_a_i    (bus.SrcA),
        .src_b_i    (bus.SrcB),
        .op_i       (bus.ALUControl),
        .start_i    (bus.Start),
        .hi_o       (hi),
        .lo_o       (lo),
        .busy_o     (bus.Busy),
        .done_o     (bus.Done),
        .div_zero_o (bus.DivZero)
    );

    assign sum  = bus.SrcA + bus.SrcB;
    assign diff = bus.SrcA - bus.SrcB;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (bus.ALUControl)
            ALU_AND:  result = bus.SrcA & bus.SrcB;
            ALU_OR:   result = bus.SrcA | bus.SrcB;
            ALU_XOR:  result = bus.SrcA ^ bus.SrcB;
            ALU_NOR:  result = ~(bus.SrcA | bus.SrcB);
            ALU_ADD: begin
                result = sum;
                ovf    = (bus.SrcA[WIDTH-1] == bus.SrcB[WIDTH-1]) &&
                         (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (bus.SrcA[WIDTH-1] != bus.SrcB[WIDTH-1]) &&
                         (diff[WIDTH-1] != bus.SrcA[WIDTH-1]);
            end
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default:  result = '0;
        endcase
    end

    assign bus.ALUResult = result;
    assign bus.ZeroFlag  = (result == '0);
    assign bus.Overflow  = ovf;

endmodule

// File: tb/tb_mips_alu_mdu.sv
// Self-checking bench for mips_alu_mdu: WIDTH=32 and WIDTH=8 instances against an arithmetic model.
module tb_mips_alu_mdu;
    import mips_alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    logic rst8;
    int   tests = 0;
    int   fails = 0;

    logic [31:0] hi_m, lo_m;
    logic        dz_m;

    always #5 clk = ~clk;

    mips_alu_mdu_if #(.WIDTH(32)) bus  ();
    mips_alu_mdu_if #(.WIDTH(8))  bus8 ();

    mips_alu_mdu #(.WIDTH(32)) dut  (.CLK(clk), .RST(rst),  .bus(bus));
    mips_alu_mdu #(.WIDTH(8))  dut8 (.CLK(clk), .RST(rst8), .bus(bus8));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    // Reference ALU from the arithmetic definitions of each operation.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                    input logic [31:0] hi, lo,
                                    output logic [31:0] res, output logic ovf);
        longint s;
        res = 32'd0;
        ovf = 1'b0;
        case (op)
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_NOR:  res = ~(a | b);
            ALU_ADD: begin
                s   = longint'($signed(a)) + longint'($signed(b));
                res = 32'(s);
                ovf = (s != longint'($signed(res)));
            end
            ALU_SUB: begin
                s   = longint'($signed(a)) - longint'($signed(b));
                res = 32'(s);
                ovf = (s != longint'($signed(res)));
            end
            ALU_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            ALU_MFHI: res = hi;
            ALU_MFLO: res = lo;
            default:  res = 32'd0;
        endcase
    endfunction

    // Launch one MDU op at the current (post-negedge) time and follow it to Done.
    task automatic launch_and_wait(input logic [3:0] op, input logic [31:0] a, b,
                                   input int pulse_at, input bit peek, input string name);
        int          n;
        int          nbusy;
        int          exp_n;
        int          exp_busy;
        logic [63:0] prod;
        logic [31:0] nh, nl;
        logic        ndz;
        if (op == ALU_MULTU) begin
            prod = 64'(a) * 64'(b);
            nh = prod[63:32]; nl = prod[31:0]; ndz = 1'b0;
            exp_n = W + 1; exp_busy = W;
        end else if (b == 32'd0) begin
            nh = a; nl = 32'hFFFF_FFFF; ndz = 1'b1;
            exp_n = 1; exp_busy = 0;
        end else begin
            nh = a % b; nl = a / b; ndz = 1'b0;
            exp_n = W + 1; exp_busy = W;
        end
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.Start      = 1'b1;
        n = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            bus.Start      = 1'b0;
            bus.ALUControl = op;
            if (bus.Busy === 1'b1) nbusy++;
            if (n == pulse_at) begin
                bus.Start = 1'b1;
                bus.SrcA  = $urandom;
                bus.SrcB  = $urandom;
            end
            if (peek && n == 2) begin
                bus.ALUControl = ALU_MFHI;
                #1;
                tests++;
                if (bus.ALUResult !== hi_m) begin
                    fails++;
                    $display("FAIL %s mfhi_during_busy: got %h expected %h", name, bus.ALUResult, hi_m);
                end
                bus.ALUControl = op;
            end
        end while (bus.Done !== 1'b1 && n < 200);
        tests++;
        if (n != exp_n) begin
            fails++;
            $display("FAIL %s done_latency: got %0d cycles expected %0d", name, n, exp_n);
        end
        tests++;
        if (nbusy != exp_busy) begin
            fails++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, nbusy, exp_busy);
        end
        hi_m = nh;
        lo_m = nl;
        dz_m = ndz;
    endtask

    // Read HI/LO through MFHI/MFLO and compare with the model, plus DivZero.
    task automatic check_hilo(input string name);
        bus.Start      = 1'b0;
        bus.ALUControl = ALU_MFHI;
        #1;
        tests++;
        if (bus.ALUResult !== hi_m || bus.ZeroFlag !== (hi_m == 32'd0)) begin
            fails++;
            $display("FAIL %s hi: got %h z=%b expected %h", name, bus.ALUResult, bus.ZeroFlag, hi_m);
        end
        bus.ALUControl = ALU_MFLO;
        #1;
        tests++;
        if (bus.ALUResult !== lo_m || bus.ZeroFlag !== (lo_m == 32'd0)) begin
            fails++;
            $display("FAIL %s lo: got %h z=%b expected %h", name, bus.ALUResult, bus.ZeroFlag, lo_m);
        end
        tests++;
        if (bus.DivZero !== dz_m) begin
            fails++;
            $display("FAIL %s divzero: got %b expected %b", name, bus.DivZero, dz_m);
        end
    endtask

    task automatic test_reset();
        bus.SrcA = '0; bus.SrcB = '0; bus.ALUControl = ALU_AND; bus.Start = 1'b0;
        bus8.SrcA = '0; bus8.SrcB = '0; bus8.ALUControl = ALU_AND; bus8.Start = 1'b0;
        rst = 1'b1;
        rst8 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rst8 = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0; dz_m = 1'b0;
        tests++;
        if ({bus.Busy, bus.Done, bus.DivZero} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000", {bus.Busy, bus.Done, bus.DivZero});
        end
        check_hilo("reset");
        bus8.ALUControl = ALU_MFHI;
        #1;
        tests++;
        if ({bus8.ALUResult, bus8.Busy, bus8.Done, bus8.DivZero} !== 11'd0) begin
            fails++;
            $display("FAIL reset_w8: got hi=%h flags=%b expected 0", bus8.ALUResult,
                     {bus8.Busy, bus8.Done, bus8.DivZero});
        end
    endtask

    task automatic test_comb();
        vec_t        vecs[10];
        logic [31:0] er;
        logic        eo;
        logic [3:0]  op;
        logic [31:0] a, b;
        vecs[0] = '{ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0};
        vecs[1] = '{ALU_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0};
        vecs[2] = '{ALU_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0};
        vecs[3] = '{ALU_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 1'b0};
        vecs[4] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[5] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[6] = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[7] = '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
        vecs[8] = '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[9] = '{4'b0101,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        bus.Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.ALUControl = vecs[i].op;
            bus.SrcA = vecs[i].a;
            bus.SrcB = vecs[i].b;
            #1;
            tests++;
            if (bus.ALUResult !== vecs[i].res || bus.Overflow !== vecs[i].ovf ||
                bus.ZeroFlag !== (vecs[i].res == 32'd0)) begin
                fails++;
                $display("FAIL comb_vec%0d: got %h ovf=%b z=%b expected %h ovf=%b", i,
                         bus.ALUResult, bus.Overflow, bus.ZeroFlag, vecs[i].res, vecs[i].ovf);
            end
        end
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (i % 5 == 0) ? a : ((i % 7 == 0) ? 32'h7FFF_FFFF : $urandom);
            @(negedge clk);
            bus.ALUControl = op;
            bus.SrcA = a;
            bus.SrcB = b;
            #1;
            ref_alu(op, a, b, hi_m, lo_m, er, eo);
            tests++;
            if (bus.ALUResult !== er || bus.Overflow !== eo || bus.ZeroFlag !== (er == 32'd0)) begin
                fails++;
                $display("FAIL comb_rand op=%b a=%h b=%h: got %h ovf=%b z=%b expected %h ovf=%b",
                         op, a, b, bus.ALUResult, bus.Overflow, bus.ZeroFlag, er, eo);
            end
        end
    endtask

    task automatic test_multu();
        @(negedge clk);
        launch_and_wait(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b1, "multu_max");
        check_hilo("multu_max");
        tests++;
        if (hi_m !== 32'hFFFF_FFFE || lo_m !== 32'h0000_0001) begin
            fails++;
            $display("FAIL multu_max_model: got %h_%h expected fffffffe_00000001", hi_m, lo_m);
        end
    endtask

    task automatic test_divu();
        logic [31:0] a, b;
        @(negedge clk);
        launch_and_wait(ALU_DIVU, 32'd100, 32'd7, 9, 1'b1, "divu_100_7");
        check_hilo("divu_100_7");
        @(negedge clk);
        launch_and_wait(ALU_DIVU, 32'd9, 32'd0, 0, 1'b0, "divu_9_0");
        check_hilo("divu_9_0");
        repeat (3) @(negedge clk);
        check_hilo("divzero_sticky");
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            @(negedge clk);
            launch_and_wait((i % 3 == 0) ? ALU_MULTU : ALU_DIVU, a, b, 0, 1'b0, "mdu_rand");
            check_hilo("mdu_rand");
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        launch_and_wait(ALU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b0, "pre_abort");
        check_hilo("pre_abort");
        @(negedge clk);
        bus.ALUControl = ALU_MULTU;
        bus.SrcA = $urandom;
        bus.SrcB = $urandom;
        bus.Start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            bus.Start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0; dz_m = 1'b0;
        tests++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            fails++;
            $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", bus.Busy, bus.Done);
        end
        check_hilo("abort");
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done === 1'b1 || bus.Busy === 1'b1) dones++;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        launch_and_wait(ALU_DIVU, $urandom, 32'($urandom_range(1, 65535)), 0, 1'b0, "b2b_first");
        check_hilo("b2b_first");
        launch_and_wait(ALU_MULTU, $urandom, $urandom, 0, 1'b0, "b2b_second");
        check_hilo("b2b_second");
        launch_and_wait(ALU_DIVU, $urandom, 32'd0, 0, 1'b0, "b2b_div0");
        launch_and_wait(ALU_DIVU, $urandom, $urandom, 0, 1'b0, "b2b_after_div0");
        check_hilo("b2b_after_div0");
    endtask

    task automatic test_width8();
        int         n;
        logic [7:0] a, b, eh, el;
        logic [3:0] op;
        logic [15:0] p;
        @(negedge clk);
        bus8.ALUControl = ALU_ADD;
        bus8.SrcA = 8'h80;
        bus8.SrcB = 8'h80;
        #1;
        tests++;
        if (bus8.ALUResult !== 8'h00 || bus8.Overflow !== 1'b1 || bus8.ZeroFlag !== 1'b1) begin
            fails++;
            $display("FAIL w8_add: got %h ovf=%b z=%b expected 00 ovf=1 z=1",
                     bus8.ALUResult, bus8.Overflow, bus8.ZeroFlag);
        end
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                op = ALU_MULTU; a = 8'd200; b = 8'd3;
            end else begin
                op = (i % 2 == 1) ? ALU_DIVU : ALU_MULTU;
                a = 8'($urandom);
                b = (i == 5) ? 8'd0 : 8'($urandom);
            end
            if (op == ALU_MULTU) begin
                p = 16'(a) * 16'(b); eh = p[15:8]; el = p[7:0];
            end else if (b == 8'd0) begin
                eh = a; el = 8'hFF;
            end else begin
                eh = a % b; el = a / b;
            end
            @(negedge clk);
            bus8.ALUControl = op;
            bus8.SrcA = a;
            bus8.SrcB = b;
            bus8.Start = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                bus8.Start = 1'b0;
                n++;
            end while (bus8.Done !== 1'b1 && n < 100);
            tests++;
            if (n != ((op == ALU_DIVU && b == 8'd0) ? 1 : 9)) begin
                fails++;
                $display("FAIL w8_latency op=%b b=%h: got %0d cycles", op, b, n);
            end
            bus8.ALUControl = ALU_MFHI;
            #1;
            tests++;
            if (bus8.ALUResult !== eh) begin
                fails++;
                $display("FAIL w8_hi op=%b a=%h b=%h: got %h expected %h", op, a, b, bus8.ALUResult, eh);
            end
            bus8.ALUControl = ALU_MFLO;
            #1;
            tests++;
            if (bus8.ALUResult !== el) begin
                fails++;
                $display("FAIL w8_lo op=%b a=%h b=%h: got %h expected %h", op, a, b, bus8.ALUResult, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_multu();
        test_divu();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mips_alu_mdu.md
Name: mips_alu_mdu

Overview:
Next-generation MIPS execute unit: a parametrised-width ALU plus an iterative multiply/divide unit (MDU) with HI/LO registers.
- Single-cycle ops are combinational, with no registered operands or result.
- MULTU/DIVU run over WIDTH cycles under a Start/Busy/Done handshake driven by the control unit's stall logic.
- Replaces the plain ALU in the datapath's execute stage.

Parameters:
- WIDTH, 32, operand/result/HI/LO width (≥4).
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- ALUControl  input  4  operation select.
- Start  input  1  launch MULTU/DIVU; qualified by ALUControl.
- ALUResult  output  WIDTH  combinational result.
- ZeroFlag  output  1  ALUResult == 0.
- Overflow  output  1  signed overflow for ADD/SUB, else 0.
- Busy  output  1  MDU iterating.
- Done  output  1  one-cycle pulse: HI/LO updated.
- DivZero  output  1  last DIVU had SrcB == 0.

Behaviour:
- Ops, combinational, same cycle, using the current HI/LO where relevant:
  - 0000 bitwise AND; 0001 bitwise OR; 0010 ADD; 0011 XOR; 0100 SUB; 1100 NOR.
  - 0110 SLT signed: result 1 or 0, zero-extended. 0111 SLTU unsigned.
  - 1010 MFHI → HI; 1011 MFLO → LO.
  - 1000 MULTU and 1001 DIVU: ALUResult = 0.
  - Any other code: ALUResult = 0, Overflow = 0.
- Overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from SrcA.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. MULTU: {HI,LO} = 2·WIDTH-bit unsigned product. DIVU: LO = quotient, HI = remainder.
- FSM states: IDLE, MUL, DIV, DONE.
  - Reset: state = IDLE; HI = LO = 0; Busy = Done = DivZero = 0; counter = 0.
  - Launch: accepted when state ∈ {IDLE, DONE} and Start = 1 and ALUControl ∈ {1000, 1001}. Start with any other code is ignored.
  - At the launch edge T0: operands latched and DivZero cleared, then:
    - MULTU: → MUL, counter = WIDTH−1.
    - DIVU with SrcB ≠ 0: → DIV, counter = WIDTH−1.
    - DIVU with SrcB = 0: → DONE directly; HI = SrcA, LO = all ones, DivZero = 1.
  - MUL: one shift-add iteration per edge (multiplier LSB-first, accumulator shift right).
  - DIV: one restoring iteration per edge (remainder shift-left, trial subtract).
  - Edge T0+WIDTH: final iteration, HI/LO written, → DONE.
  - Busy = 1 exactly in MUL/DIV, i.e. the WIDTH cycles after T0.
  - DONE: Done = 1, Busy = 0, held one cycle. Then → IDLE, or → MUL/DIV if a new launch is accepted in that cycle (back-to-back allowed).
- Latency: Done is observed WIDTH+1 cycles after the cycle where Start was sampled. The divide-by-zero path takes 1 cycle.
- Start while Busy: ignored, no queuing. Operand changes during Busy have no effect.
- HI/LO change only at operation completion or on reset. MFHI/MFLO during Busy return the previous values.
- DivZero is sticky until the next accepted launch.
- RST mid-operation: abort, → IDLE, HI/LO cleared, no Done pulse.
- ZeroFlag follows ALUResult in all modes, including MFHI/MFLO.

Decomposition:
- Package mips_alu_pkg holds:
  - ALUControl encodings as 4-bit localparams (ALU_AND … ALU_MFLO).
  - The FSM state enum {S_IDLE, S_MUL, S_DIV, S_DONE}.
- Sub-module mips_mdu_seq holds the FSM, counter, HI/LO and iteration datapath. The top keeps the combinational ALU and the output mux.

Test Plan:
- Combinational ops, WIDTH=32:
  - SrcA=0xF0F0_00FF, SrcB=0x0FF0_0F0F.
  - AND → 0x00F0_000F; OR → 0xFFF0_0FFF; XOR → 0xFF00_0FF0; NOR → 0x000F_F000.
  - SLT(0xFFFF_FFFF, 1) → 1; SLTU on the same operands → 0.
- Overflow:
  - ADD 0x7FFF_FFFF+1 → 0x8000_0000, Overflow=1.
  - SUB 5−5 → 0, ZeroFlag=1, Overflow=0.
- MULTU 0xFFFF_FFFF×0xFFFF_FFFF with Start for one cycle:
  - Busy high 32 cycles; Done on cycle 33.
  - MFHI → 0xFFFF_FFFE; MFLO → 0x0000_0001.
  - Start pulsed mid-Busy is ignored.
- DIVU 100/7:
  - After Done: LO=14, HI=2, DivZero=0.
  - Then DIVU 9/0: Done next cycle, HI=9, LO=0xFFFF_FFFF, DivZero=1.
- Reset and back-to-back:
  - RST asserted at iteration 10 of a MULTU: next cycle Busy=0, HI=LO=0, no Done.
  - Relaunch in the DONE cycle: the second op completes normally.
- WIDTH=8:
  - MULTU 200×3 → HI=0x02, LO=0x58; Done 9 cycles after Start.
  - ADD 0x80+0x80 → 0x00, Overflow=1, ZeroFlag=1.
